// File: rtl/reservation_station_aged.sv
// Reservation station with multi-port CDB wakeup, head-relative ROB ages and mispredict flush.
// Optional macro RS_OLDEST_FIRST_EN: oldest-ready issue; when undefined, the lowest-index ready entry issues.
module reservation_station_aged #(
   parameter int PREG_WIDTH = 7,
   parameter int ROB_WIDTH  = 4,
   parameter int RS_SIZE    = 8,
   parameter int CDB_PORTS  = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            i_valid,
   input  logic [31:0]                     i_pc,
   input  logic [PREG_WIDTH-1:0]           i_prs1,
   input  logic [PREG_WIDTH-1:0]           i_prs2,
   input  logic [PREG_WIDTH-1:0]           i_prd,
   input  logic [ROB_WIDTH-1:0]            i_rob_tag,
   input  logic [31:0]                     i_imm,
   input  logic [3:0]                      i_alu_op,
   input  logic                            i_alusrc,
   input  logic                            i_memwrite,
   input  logic                            i_rs1_ready,
   input  logic                            i_rs2_ready,
   output logic                            o_full,
   output logic [$clog2(RS_SIZE+1)-1:0]    o_count,
   input  logic [CDB_PORTS-1:0]            i_cdb_valid,
   input  logic [CDB_PORTS*PREG_WIDTH-1:0] i_cdb_prd,
   input  logic [ROB_WIDTH-1:0]            i_rob_head,
   input  logic                            i_eu_ready,
   output logic                            o_issue_valid,
   output logic [PREG_WIDTH-1:0]           o_issue_prs1,
   output logic [PREG_WIDTH-1:0]           o_issue_prs2,
   output logic [PREG_WIDTH-1:0]           o_issue_prd,
   output logic [ROB_WIDTH-1:0]            o_issue_rob_tag,
   output logic [31:0]                     o_issue_imm,
   output logic [3:0]                      o_issue_alu_op,
   output logic [31:0]                     o_issue_pc,
   output logic                            o_issue_alusrc,
   output logic                            o_issue_memwrite,
   input  logic                            branch_mispredict,
   input  logic [ROB_WIDTH-1:0]            mispredict_rob_tag
);

   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int CNT_W = $clog2(RS_SIZE+1);

   logic [RS_SIZE-1:0]    valid_q;
   logic [RS_SIZE-1:0]    rs1_rdy_q;
   logic [RS_SIZE-1:0]    rs2_rdy_q;
   logic [CNT_W-1:0]      count_q;

   logic [PREG_WIDTH-1:0] prs1_q    [RS_SIZE];
   logic [PREG_WIDTH-1:0] prs2_q    [RS_SIZE];
   logic [PREG_WIDTH-1:0] prd_q     [RS_SIZE];
   logic [ROB_WIDTH-1:0]  rob_tag_q [RS_SIZE];
   logic [31:0]           imm_q     [RS_SIZE];
   logic [31:0]           pc_q      [RS_SIZE];
   logic [3:0]            alu_op_q  [RS_SIZE];
   logic [RS_SIZE-1:0]    alusrc_q;
   logic [RS_SIZE-1:0]    memwrite_q;

   logic                  free_found;
   logic [IDX_W-1:0]      alloc_idx;
   logic                  issue_found;
   logic [IDX_W-1:0]      sel_idx;
   logic                  do_alloc;
   logic                  do_issue;
   logic                  alloc_rs1_rdy;
   logic                  alloc_rs2_rdy;
   logic [RS_SIZE-1:0]    wake1;
   logic [RS_SIZE-1:0]    wake2;
   logic [RS_SIZE-1:0]    kill;
   logic [ROB_WIDTH-1:0]  entry_age [RS_SIZE];
   logic [ROB_WIDTH-1:0]  mis_age;
   logic [CNT_W-1:0]      kept_count;

   // Preg 0 is the hardwired zero register, so a broadcast of it never wakes anything.
   function automatic logic cdb_match(input logic [PREG_WIDTH-1:0]           preg,
                                      input logic [CDB_PORTS-1:0]            cv,
                                      input logic [CDB_PORTS*PREG_WIDTH-1:0] cp);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < CDB_PORTS; k++) begin
         if (cv[k] && (cp[k*PREG_WIDTH +: PREG_WIDTH] == preg))
            hit = 1'b1;
      end
      return hit && (preg != '0);
   endfunction

   always_comb begin
      free_found = 1'b0;
      alloc_idx  = '0;
      for (int i = RS_SIZE-1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            alloc_idx  = IDX_W'(i);
         end
      end
   end

   always_comb begin
      mis_age    = mispredict_rob_tag - i_rob_head;
      kept_count = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         entry_age[i] = rob_tag_q[i] - i_rob_head;
         kill[i]      = valid_q[i] && (entry_age[i] > mis_age);
         wake1[i]     = cdb_match(prs1_q[i], i_cdb_valid, i_cdb_prd);
         wake2[i]     = cdb_match(prs2_q[i], i_cdb_valid, i_cdb_prd);
         kept_count   = kept_count + CNT_W'(valid_q[i] && !kill[i]);
      end
   end

`ifdef RS_OLDEST_FIRST_EN
   logic [ROB_WIDTH-1:0] best_age;

   // Strict less-than keeps the lower index on equal ages.
   always_comb begin
      issue_found = 1'b0;
      sel_idx     = '0;
      best_age    = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i] &&
             (!issue_found || (entry_age[i] < best_age))) begin
            issue_found = 1'b1;
            sel_idx     = IDX_W'(i);
            best_age    = entry_age[i];
         end
      end
   end
`else
   always_comb begin
      issue_found = 1'b0;
      sel_idx     = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i] && !issue_found) begin
            issue_found = 1'b1;
            sel_idx     = IDX_W'(i);
         end
      end
   end
`endif

   assign alloc_rs1_rdy = i_rs1_ready || cdb_match(i_prs1, i_cdb_valid, i_cdb_prd);
   assign alloc_rs2_rdy = i_rs2_ready || cdb_match(i_prs2, i_cdb_valid, i_cdb_prd);
   assign do_alloc      = i_valid && free_found && !branch_mispredict;
   assign do_issue      = issue_found && i_eu_ready && !branch_mispredict;

   // Alloc targets an invalid slot and issue a valid one, so both can update the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= '0;
         rs1_rdy_q <= '0;
         rs2_rdy_q <= '0;
         count_q   <= '0;
      end else if (branch_mispredict) begin
         valid_q   <= valid_q & ~kill;
         count_q   <= kept_count;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && wake1[i])
               rs1_rdy_q[i] <= 1'b1;
            if (valid_q[i] && wake2[i])
               rs2_rdy_q[i] <= 1'b1;
            if (do_issue && (sel_idx == IDX_W'(i))) begin
               valid_q[i]   <= 1'b0;
               rs1_rdy_q[i] <= 1'b0;
               rs2_rdy_q[i] <= 1'b0;
            end
            if (do_alloc && (alloc_idx == IDX_W'(i))) begin
               valid_q[i]   <= 1'b1;
               rs1_rdy_q[i] <= alloc_rs1_rdy;
               rs2_rdy_q[i] <= alloc_rs2_rdy;
            end
         end
         count_q <= count_q + CNT_W'(do_alloc) - CNT_W'(do_issue);
      end
   end

   always_ff @(posedge clk) begin
      if (do_alloc) begin
         prs1_q[alloc_idx]     <= i_prs1;
         prs2_q[alloc_idx]     <= i_prs2;
         prd_q[alloc_idx]      <= i_prd;
         rob_tag_q[alloc_idx]  <= i_rob_tag;
         imm_q[alloc_idx]      <= i_imm;
         pc_q[alloc_idx]       <= i_pc;
         alu_op_q[alloc_idx]   <= i_alu_op;
         alusrc_q[alloc_idx]   <= i_alusrc;
         memwrite_q[alloc_idx] <= i_memwrite;
      end
   end

   assign o_full           = !free_found;
   assign o_count          = count_q;
   assign o_issue_valid    = issue_found;
   assign o_issue_prs1     = issue_found ? prs1_q[sel_idx]     : '0;
   assign o_issue_prs2     = issue_found ? prs2_q[sel_idx]     : '0;
   assign o_issue_prd      = issue_found ? prd_q[sel_idx]      : '0;
   assign o_issue_rob_tag  = issue_found ? rob_tag_q[sel_idx]  : '0;
   assign o_issue_imm      = issue_found ? imm_q[sel_idx]      : '0;
   assign o_issue_pc       = issue_found ? pc_q[sel_idx]       : '0;
   assign o_issue_alu_op   = issue_found ? alu_op_q[sel_idx]   : '0;
   assign o_issue_alusrc   = issue_found ? alusrc_q[sel_idx]   : 1'b0;
   assign o_issue_memwrite = issue_found ? memwrite_q[sel_idx] : 1'b0;

endmodule

// File: tb/tb_reservation_station_aged.sv
// Directed bench for reservation_station_aged: a vector table plus hand-written multi-cycle sequences.
module tb_reservation_station_aged;

`ifdef RS_OLDEST_FIRST_EN
   localparam bit OLD = 1'b1;
`else
   localparam bit OLD = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        i_valid;
   logic [31:0] i_pc;
   logic [6:0]  i_prs1, i_prs2, i_prd;
   logic [3:0]  i_rob_tag;
   logic [31:0] i_imm;
   logic [3:0]  i_alu_op;
   logic        i_alusrc, i_memwrite, i_rs1_ready, i_rs2_ready;
   logic        o_full;
   logic [3:0]  o_count;
   logic [1:0]  i_cdb_valid;
   logic [13:0] i_cdb_prd;
   logic [3:0]  i_rob_head;
   logic        i_eu_ready;
   logic        o_issue_valid;
   logic [6:0]  o_issue_prs1, o_issue_prs2, o_issue_prd;
   logic [3:0]  o_issue_rob_tag;
   logic [31:0] o_issue_imm;
   logic [3:0]  o_issue_alu_op;
   logic [31:0] o_issue_pc;
   logic        o_issue_alusrc, o_issue_memwrite;
   logic        branch_mispredict;
   logic [3:0]  mispredict_rob_tag;

   int compared;
   int mismatched;

   typedef struct {
      logic       valid;
      logic [6:0] prs1;
      logic       rs1_rdy;
      logic [6:0] prd;
      logic [3:0] tag;
      logic       eu_ready;
      logic [1:0] cdb_valid;
      logic [13:0] cdb_prd;
      logic       exp_full;
      logic [3:0] exp_count;
      logic       exp_iv;
      logic [6:0] exp_prd;
      logic [3:0] exp_tag;
   } vec_t;

   vec_t vecs [14];

   reservation_station_aged dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_pc(i_pc),
      .i_prs1(i_prs1), .i_prs2(i_prs2), .i_prd(i_prd), .i_rob_tag(i_rob_tag),
      .i_imm(i_imm), .i_alu_op(i_alu_op), .i_alusrc(i_alusrc), .i_memwrite(i_memwrite),
      .i_rs1_ready(i_rs1_ready), .i_rs2_ready(i_rs2_ready),
      .o_full(o_full), .o_count(o_count),
      .i_cdb_valid(i_cdb_valid), .i_cdb_prd(i_cdb_prd), .i_rob_head(i_rob_head),
      .i_eu_ready(i_eu_ready), .o_issue_valid(o_issue_valid),
      .o_issue_prs1(o_issue_prs1), .o_issue_prs2(o_issue_prs2), .o_issue_prd(o_issue_prd),
      .o_issue_rob_tag(o_issue_rob_tag), .o_issue_imm(o_issue_imm),
      .o_issue_alu_op(o_issue_alu_op), .o_issue_pc(o_issue_pc),
      .o_issue_alusrc(o_issue_alusrc), .o_issue_memwrite(o_issue_memwrite),
      .branch_mispredict(branch_mispredict), .mispredict_rob_tag(mispredict_rob_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t makeVec(input logic v, input logic [6:0] prs1, input logic r1,
                                    input logic [6:0] prd, input logic [3:0] tag, input logic eu,
                                    input logic [1:0] cv, input logic [13:0] cp,
                                    input logic ef, input logic [3:0] ec, input logic eiv,
                                    input logic [6:0] eprd, input logic [3:0] etag);
      vec_t r;
      r.valid = v;      r.prs1 = prs1;   r.rs1_rdy = r1;  r.prd = prd;     r.tag = tag;
      r.eu_ready = eu;  r.cdb_valid = cv; r.cdb_prd = cp;
      r.exp_full = ef;  r.exp_count = ec; r.exp_iv = eiv; r.exp_prd = eprd; r.exp_tag = etag;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      i_valid = 1'b0; i_pc = '0; i_prs1 = '0; i_prs2 = '0; i_prd = '0; i_rob_tag = '0;
      i_imm = '0; i_alu_op = '0; i_alusrc = 1'b0; i_memwrite = 1'b0;
      i_rs1_ready = 1'b0; i_rs2_ready = 1'b0; i_cdb_valid = '0; i_cdb_prd = '0;
      i_eu_ready = 1'b0; branch_mispredict = 1'b0; mispredict_rob_tag = '0;
   endtask

   task automatic doReset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic alloc(input logic [6:0] prs1, input logic r1, input logic [6:0] prs2, input logic r2,
                        input logic [6:0] prd, input logic [3:0] tag);
      i_valid = 1'b1; i_prs1 = prs1; i_rs1_ready = r1; i_prs2 = prs2; i_rs2_ready = r2;
      i_prd = prd; i_rob_tag = tag; i_pc = 32'h1000 + 32'(prd);
   endtask

   task automatic applyStimulus(input vec_t v);
      idle();
      i_valid = v.valid; i_prs1 = v.prs1; i_rs1_ready = v.rs1_rdy;
      i_prs2 = '0; i_rs2_ready = 1'b1; i_prd = v.prd; i_rob_tag = v.tag;
      i_pc = 32'h1000 + 32'(v.prd);
      i_eu_ready = v.eu_ready; i_cdb_valid = v.cdb_valid; i_cdb_prd = v.cdb_prd;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      i_rob_head = '0;
      idle();

      // Fill 8 slots while the EU stalls, drop a 9th, then drain with a wakeup mixed in.
      for (int i = 0; i < 8; i++)
         vecs[i] = makeVec(1'b1, 7'd0, 1'b1, 7'(10 + i), 4'(i), 1'b0, 2'b00, 14'd0,
                           i == 7, 4'(i + 1), 1'b1, 7'd10, 4'd0);
      vecs[8]  = makeVec(1'b1, 7'd0,  1'b1, 7'd30, 4'd8, 1'b0, 2'b00, 14'd0, 1'b1, 4'd8, 1'b1, 7'd10, 4'd0);
      vecs[9]  = makeVec(1'b1, 7'd0,  1'b1, 7'd31, 4'd9, 1'b1, 2'b00, 14'd0, 1'b0, 4'd7, 1'b1, 7'd11, 4'd1);
      vecs[10] = makeVec(1'b0, 7'd0,  1'b0, 7'd0,  4'd0, 1'b1, 2'b00, 14'd0, 1'b0, 4'd6, 1'b1, 7'd12, 4'd2);
      vecs[11] = makeVec(1'b1, 7'd50, 1'b0, 7'd40, 4'd8, 1'b0, 2'b00, 14'd0, 1'b0, 4'd7, 1'b1, 7'd12, 4'd2);
      vecs[12] = makeVec(1'b0, 7'd0,  1'b0, 7'd0,  4'd0, 1'b1, 2'b10, {7'd50, 7'd0}, 1'b0, 4'd6, 1'b1,
                         OLD ? 7'd13 : 7'd40, OLD ? 4'd3 : 4'd8);
      vecs[13] = makeVec(1'b0, 7'd0,  1'b0, 7'd0,  4'd0, 1'b1, 2'b00, 14'd0, 1'b0, 4'd5, 1'b1,
                         OLD ? 7'd14 : 7'd13, OLD ? 4'd4 : 4'd3);

      @(negedge clk);
      doReset();
      checkOutput("reset full",  32'(o_full), 32'd0);
      checkOutput("reset count", 32'(o_count), 32'd0);
      checkOutput("reset issue_valid", 32'(o_issue_valid), 32'd0);
      checkOutput("reset issue_prd", 32'(o_issue_prd), 32'd0);
      checkOutput("reset issue_pc", o_issue_pc, 32'd0);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d full", i), 32'(o_full), 32'(vecs[i].exp_full));
         checkOutput($sformatf("vec%0d count", i), 32'(o_count), 32'(vecs[i].exp_count));
         checkOutput($sformatf("vec%0d issue_valid", i), 32'(o_issue_valid), 32'(vecs[i].exp_iv));
         checkOutput($sformatf("vec%0d issue_prd", i), 32'(o_issue_prd), 32'(vecs[i].exp_prd));
         checkOutput($sformatf("vec%0d issue_tag", i), 32'(o_issue_rob_tag), 32'(vecs[i].exp_tag));
      end

      // Age selection: head=2, tag 5 in slot 0 and tag 2 in slot 1.
      doReset();
      i_rob_head = 4'd2;
      alloc(7'd0, 1'b1, 7'd0, 1'b1, 7'd21, 4'd5);
      tick();
      idle();
      alloc(7'd0, 1'b1, 7'd0, 1'b1, 7'd22, 4'd2);
      tick();
      idle();
      checkOutput("age first tag", 32'(o_issue_rob_tag), OLD ? 32'd2 : 32'd5);
      checkOutput("age first pc", o_issue_pc, OLD ? 32'h1016 : 32'h1015);
      i_eu_ready = 1'b1;
      tick();
      idle();
      checkOutput("age second tag", 32'(o_issue_rob_tag), OLD ? 32'd5 : 32'd2);
      checkOutput("age count", 32'(o_count), 32'd1);

      // Wrap-around flush: head=14, tags 14,15,0,1; mispredict on 15.
      doReset();
      i_rob_head = 4'd14;
      for (int t = 0; t < 4; t++) begin
         alloc(7'd0, 1'b1, 7'd0, 1'b1, 7'(60 + t), 4'(14 + t));
         tick();
      end
      idle();
      checkOutput("wrap pre count", 32'(o_count), 32'd4);
      branch_mispredict  = 1'b1;
      mispredict_rob_tag = 4'd15;
      alloc(7'd0, 1'b1, 7'd0, 1'b1, 7'd64, 4'd2);
      i_eu_ready = 1'b1;
      tick();
      idle();
      checkOutput("flush count", 32'(o_count), 32'd2);
      checkOutput("flush full", 32'(o_full), 32'd0);
      checkOutput("flush issue tag", 32'(o_issue_rob_tag), 32'd14);
      i_eu_ready = 1'b1;
      tick();
      checkOutput("flush next tag", 32'(o_issue_rob_tag), 32'd15);
      checkOutput("flush next count", 32'(o_count), 32'd1);
      tick();
      idle();
      checkOutput("flush drained valid", 32'(o_issue_valid), 32'd0);
      checkOutput("flush drained count", 32'(o_count), 32'd0);
      i_rob_head = 4'd0;

      // Dual-port wakeup in one cycle.
      doReset();
      alloc(7'd9, 1'b0, 7'd12, 1'b0, 7'd33, 4'd3);
      tick();
      idle();
      checkOutput("dual waiting", 32'(o_issue_valid), 32'd0);
      i_cdb_valid = 2'b01;
      i_cdb_prd   = {7'd0, 7'd10};
      tick();
      checkOutput("dual unrelated", 32'(o_issue_valid), 32'd0);
      i_cdb_valid = 2'b11;
      i_cdb_prd   = {7'd12, 7'd9};
      tick();
      idle();
      checkOutput("dual woke", 32'(o_issue_valid), 32'd1);
      checkOutput("dual prd", 32'(o_issue_prd), 32'd33);

      // Preg 0 never wakes; dispatch-time CDB capture.
      doReset();
      alloc(7'd0, 1'b0, 7'd5, 1'b1, 7'd44, 4'd1);
      i_cdb_valid = 2'b01;
      i_cdb_prd   = 14'd0;
      tick();
      idle();
      i_cdb_valid = 2'b11;
      i_cdb_prd   = 14'd0;
      tick();
      idle();
      checkOutput("preg0 no wake", 32'(o_issue_valid), 32'd0);
      alloc(7'd20, 1'b0, 7'd0, 1'b1, 7'd45, 4'd2);
      i_cdb_valid = 2'b10;
      i_cdb_prd   = {7'd20, 7'd0};
      tick();
      idle();
      checkOutput("capture valid", 32'(o_issue_valid), 32'd1);
      checkOutput("capture prd", 32'(o_issue_prd), 32'd45);
      checkOutput("capture count", 32'(o_count), 32'd2);

      // EU backpressure for 3 cycles, then issue.
      doReset();
      alloc(7'd3, 1'b1, 7'd4, 1'b1, 7'd50, 4'd0);
      i_imm = 32'hDEADBEEF; i_alu_op = 4'hA; i_alusrc = 1'b1; i_memwrite = 1'b1;
      tick();
      idle();
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("stall%0d valid", c), 32'(o_issue_valid), 32'd1);
         checkOutput($sformatf("stall%0d prd", c), 32'(o_issue_prd), 32'd50);
         checkOutput($sformatf("stall%0d count", c), 32'(o_count), 32'd1);
      end
      checkOutput("payload imm", o_issue_imm, 32'hDEADBEEF);
      checkOutput("payload alu_op", 32'(o_issue_alu_op), 32'hA);
      checkOutput("payload alusrc", 32'(o_issue_alusrc), 32'd1);
      checkOutput("payload memwrite", 32'(o_issue_memwrite), 32'd1);
      checkOutput("payload prs2", 32'(o_issue_prs2), 32'd4);
      i_eu_ready = 1'b1;
      tick();
      idle();
      checkOutput("stall issued valid", 32'(o_issue_valid), 32'd0);
      checkOutput("stall issued count", 32'(o_count), 32'd0);
      checkOutput("stall issued prd", 32'(o_issue_prd), 32'd0);

      // Reset mid-operation discards pending entries.
      alloc(7'd0, 1'b1, 7'd0, 1'b1, 7'd70, 4'd1);
      tick();
      alloc(7'd0, 1'b1, 7'd0, 1'b1, 7'd71, 4'd2);
      tick();
      idle();
      checkOutput("pre midreset count", 32'(o_count), 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midreset count", 32'(o_count), 32'd0);
      checkOutput("midreset valid", 32'(o_issue_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/reservation_station_aged.md
# reservation_station_aged

Parametrised successor to the single-CDB reservation station. It sits between dispatch and one execution unit. It buffers renamed micro-ops until their operands are ready and wakes them from multiple CDB ports in parallel. It issues the oldest ready entry by ROB age and flushes on mispredict with correct ROB-tag wrap-around, measured relative to the ROB head.

## Interface
Parameters:
- PREG_WIDTH, 7, physical register index width
- ROB_WIDTH, 4, ROB tag width; ROB depth = 2^ROB_WIDTH
- RS_SIZE, 8, number of entries (2..32)
- CDB_PORTS, 2, number of parallel wakeup ports (1..4)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- i_valid  in  1  allocate request
- i_pc  in  32  instruction PC
- i_prs1, i_prs2  in  PREG_WIDTH  source pregs
- i_prd  in  PREG_WIDTH  destination preg
- i_rob_tag  in  ROB_WIDTH  ROB tag
- i_imm  in  32  immediate
- i_alu_op  in  4  ALU opcode
- i_alusrc  in  1  operand-2 select
- i_memwrite  in  1  store flag
- i_rs1_ready, i_rs2_ready  in  1  operand ready at dispatch
- o_full  out  1  no free entry
- o_count  out  $clog2(RS_SIZE+1)  number of valid entries
- i_cdb_valid  in  CDB_PORTS  per-port broadcast valid
- i_cdb_prd  in  CDB_PORTS*PREG_WIDTH  per-port preg; port k occupies bits [k*PREG_WIDTH +: PREG_WIDTH]
- i_rob_head  in  ROB_WIDTH  tag of the oldest in-flight instruction
- i_eu_ready  in  1  EU accepts issue this cycle
- o_issue_valid  out  1  issue candidate present
- o_issue_prs1/prs2/prd/rob_tag/imm/alu_op/pc/alusrc/memwrite  out  as inputs  selected entry fields
- branch_mispredict  in  1  flush request
- mispredict_rob_tag  in  ROB_WIDTH  tag of the mispredicting branch

## Operation
- Entry fields: valid, rs1_ready, rs2_ready, plus all payload fields captured at allocation.
- Age of a tag: (tag − i_rob_head) mod 2^ROB_WIDTH, computed in ROB_WIDTH bits. Smaller age means older.
- Allocation:
  - Occurs when i_valid && !o_full.
  - The target is the lowest-index invalid entry in the registered state.
  - Ready bits are set to i_rsX_ready OR'd with a match on any valid CDB port with the same preg, excluding preg 0.
  - i_valid while o_full: the request is dropped; dispatch must stall.
- Wakeup: for every valid entry and every port k with i_cdb_valid[k], prsX == i_cdb_prd[k], and prsX != 0, set rsX_ready. Multiple ports matching the same entry is legal.
- Issue selection:
  - Candidates are valid entries with both ready bits set, in the registered state.
  - Select the candidate with minimum age; break ties by lower index.
  - o_issue_* reflect the selected entry; all are zero when o_issue_valid=0.
- Issue commit: when o_issue_valid && i_eu_ready, the selected entry's valid, rs1_ready and rs2_ready are cleared at the next edge.
- Flush:
  - When branch_mispredict, every valid entry with age(rob_tag) > age(mispredict_rob_tag) is invalidated.
  - Entries with age less than or equal to it, including the branch itself, are kept.
- Priority within one cycle: reset > branch_mispredict > {allocate, wakeup, issue}.
  - During a flush, allocation, wakeup and issue commit are all suppressed.
  - o_issue_valid may still be high combinationally; the EU must qualify it with branch_mispredict.
- o_count tracks valid entries and is registered. Its per-cycle update is +alloc −issue, or it is recomputed after a flush.

## Timing
- Reset values: all entries invalid, o_full=0, o_count=0, o_issue_valid=0, all o_issue_* = 0.
- Reset applied mid-operation empties the RS at the next edge; pending entries are lost.
- Dispatch-to-issue: minimum latency is 1 cycle. An entry allocated ready at edge N is an issue candidate in cycle N+1.
- Wakeup-to-issue: 1 cycle. A CDB hit at edge N makes the entry a candidate in cycle N+1. No same-cycle CDB→issue bypass.
- Issue output is combinational from registered state.
- Issue has a valid/ready handshake: if i_eu_ready=0, the entry stays valid and the selection is re-evaluated next cycle. An older entry that became ready may then replace it.
- Allocation and issue in the same cycle:
  - The freed slot is not reusable until the next cycle.
  - o_full is computed from registered state only, so a full RS issuing this cycle still reports o_full=1.
- Wrap-around: ages are correct for any head position, provided in-flight tags span fewer than 2^ROB_WIDTH entries.

## Configuration
- RS_OLDEST_FIRST_EN:
  - Defined: age-based issue selection as described.
  - Undefined: issue selects the lowest-index ready entry and i_rob_head is unused for selection. Flush still uses head-relative age.

## Test plan
- Reset, then allocate 8 ready entries → o_full=1 and o_count=8 after the 8th edge. A 9th i_valid is dropped, and o_count stays 8.
- Allocate tag 5 (slot 0) and tag 2 (slot 1), both ready, with head=2 → tag 2 issues first (slot 1). With the macro undefined, slot 0 issues first.
- Head=14: allocate tags 14, 15, 0, 1; mispredict on tag 15 → tags 0 and 1 are flushed, tags 14 and 15 remain, and o_count=2.
- Entry waiting on prs1=9 and prs2=12; CDB port 0 carries 9 and port 1 carries 12 in the same cycle → the entry issues the next cycle.
- Allocate with prs1=20 not ready while CDB port 1 broadcasts 20 in the same cycle → the entry is captured ready and issues 1 cycle later. A broadcast of preg 0 never wakes anything.
- Ready entry with i_eu_ready=0 for 3 cycles → o_issue_valid stays high and the entry is retained. It issues on the cycle i_eu_ready=1, and the entry is invalid at the next edge.
